// File: rtl/apu_req_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : apu_req_queue_if
// Brief    : CPU-side and accelerator-side APU signals of apu_req_queue.
// Revision : 1.0 - initial release
// ============================================================================
interface apu_req_queue_if #(
  parameter int DEPTH = 4
);
  logic                         cpu_req_i;
  logic [2:0][31:0]             cpu_operands_i;
  logic [5:0]                   cpu_op_i;
  logic [14:0]                  cpu_flags_i;
  logic                         cpu_gnt_o;
  logic                         cpu_rvalid_o;
  logic [31:0]                  cpu_result_o;
  logic                         acc_req_o;
  logic [2:0][31:0]             acc_operands_o;
  logic [5:0]                   acc_op_o;
  logic [14:0]                  acc_flags_o;
  logic                         acc_gnt_i;
  logic                         acc_rvalid_i;
  logic [31:0]                  acc_result_i;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  // Queue side
  modport slave (
    input  cpu_req_i, cpu_operands_i, cpu_op_i, cpu_flags_i,
    input  acc_gnt_i, acc_rvalid_i, acc_result_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_result_o,
    output acc_req_o, acc_operands_o, acc_op_o, acc_flags_o, count_o
  );

  // CPU/accelerator environment side
  modport master (
    output cpu_req_i, cpu_operands_i, cpu_op_i, cpu_flags_i,
    output acc_gnt_i, acc_rvalid_i, acc_result_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_result_o,
    input  acc_req_o, acc_operands_o, acc_op_o, acc_flags_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/apu_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : apu_req_queue
// Brief    : APU request FIFO with outstanding-response limit and registered
//            result return. Optional macro APU_REQ_QUEUE_BYPASS_EN enables the
//            empty-queue cut-through from CPU to accelerator.
// Revision : 1.0 - initial release
// ============================================================================
module apu_req_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  wire logic       clk,
  input  wire logic       n_reset,
  apu_req_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] c_full     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [OUT_W-1:0] c_out_max  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] c_out_one  = OUT_W'(1);
  localparam logic [OUT_W-1:0] c_out_zero = '0;

  typedef struct packed {
    logic [2:0][31:0] operands;
    logic [5:0]       op;
    logic [14:0]      flags;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [OUT_W-1:0] r_outstanding;
  logic             r_rvalid;
  logic [31:0]      r_result;

  entry_t w_cpu_entry;
  entry_t w_head;
  entry_t w_acc_entry;
  logic   w_empty;
  logic   w_full;
  logic   w_out_full;
  logic   w_cpu_gnt;
  logic   w_bypass;
  logic   w_byp_take;
  logic   w_pop;
  logic   w_push;
  logic   w_issue;
  logic   w_rsp;

  assign w_cpu_entry = '{operands: bus.cpu_operands_i, op: bus.cpu_op_i, flags: bus.cpu_flags_i};
  assign w_head      = r_mem[r_rd_ptr];

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_full);
  assign w_out_full = (r_outstanding == c_out_max);

`ifdef APU_REQ_QUEUE_BYPASS_EN
  // Empty queue with issue credit: present the CPU request directly.
  assign w_bypass    = w_empty & ~w_out_full & bus.cpu_req_i;
  assign w_acc_entry = w_bypass ? w_cpu_entry : w_head;
`else
  assign w_bypass    = 1'b0;
  assign w_acc_entry = w_head;
`endif

  assign w_cpu_gnt  = bus.cpu_req_i & ~w_full;
  assign w_pop      = ~w_empty & ~w_out_full & bus.acc_gnt_i;
  assign w_byp_take = w_bypass & bus.acc_gnt_i;
  assign w_push     = w_cpu_gnt & ~w_byp_take;
  assign w_issue    = w_pop | w_byp_take;
  // Responses with nothing in flight (e.g. issued before reset) are dropped.
  assign w_rsp      = bus.acc_rvalid_i & (r_outstanding != c_out_zero);

  assign bus.cpu_gnt_o      = w_cpu_gnt;
  assign bus.acc_req_o      = (~w_empty & ~w_out_full) | w_bypass;
  assign bus.acc_operands_o = w_acc_entry.operands;
  assign bus.acc_op_o       = w_acc_entry.op;
  assign bus.acc_flags_o    = w_acc_entry.flags;
  assign bus.cpu_rvalid_o   = r_rvalid;
  assign bus.cpu_result_o   = r_result;
  assign bus.count_o        = r_count;

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_cpu_entry;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_outstanding <= '0;
    end else if (w_issue && !w_rsp) begin
      r_outstanding <= r_outstanding + c_out_one;
    end else if (w_rsp && !w_issue) begin
      r_outstanding <= r_outstanding - c_out_one;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_rvalid <= 1'b0;
      r_result <= '0;
    end else begin
      r_rvalid <= w_rsp;
      if (w_rsp) begin
        r_result <= bus.acc_result_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apu_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_req_queue
// Brief    : Directed self-checking bench for apu_req_queue (DEPTH=4, MAX_OUTSTANDING=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apu_req_queue;

  logic clk;
  logic n_reset;
  int   n_tests;
  int   n_fail;

  apu_req_queue_if #(.DEPTH(4)) bus ();

  apu_req_queue #(
    .DEPTH          (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [5:0]  op;
    logic        gnt;
    logic        rvalid;
    logic [31:0] result;
    logic        e_gnt;
    logic        e_req;
    logic [5:0]  e_op;
    logic [2:0]  e_count;
    logic        e_rvalid;
    logic [31:0] e_result;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_reset = 1'b0;
    bus.cpu_req_i      = 1'b0;
    bus.cpu_operands_i = {32'd3, 32'd2, 32'd1};
    bus.cpu_op_i       = '0;
    bus.cpu_flags_i    = 15'h1234;
    bus.acc_gnt_i      = 1'b0;
    bus.acc_rvalid_i   = 1'b0;
    bus.acc_result_i   = '0;

    // Single op with gnt tied high, then a stray response.
    vt[0] = '{1'b1, 6'h01, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 6'h00, 3'd0, 1'b0, 32'h0};
    vt[1] = '{1'b0, 6'h01, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 6'h01, 3'd1, 1'b0, 32'h0};
    vt[2] = '{1'b0, 6'h01, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 32'h0};
    vt[3] = '{1'b0, 6'h01, 1'b1, 1'b1, 32'h10,   1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 32'h0};
    vt[4] = '{1'b0, 6'h01, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 6'h00, 3'd0, 1'b1, 32'h10};
    vt[5] = '{1'b0, 6'h01, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 32'h10};
    vt[6] = '{1'b0, 6'h01, 1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 32'h10};
    vt[7] = '{1'b0, 6'h01, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 32'h10};

    // Reset state (asynchronous, before any clock edge)
    #2;
    chk("rst_acc_req", 128'(bus.acc_req_o), 128'(0));
    chk("rst_count",   128'(bus.count_o), 128'(0));
    chk("rst_rvalid",  128'(bus.cpu_rvalid_o), 128'(0));
    chk("rst_result",  128'(bus.cpu_result_o), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;

`ifndef APU_REQ_QUEUE_BYPASS_EN
    for (int i = 0; i < 8; i++) begin
      bus.cpu_req_i    = vt[i].req;
      bus.cpu_op_i     = vt[i].op;
      bus.acc_gnt_i    = vt[i].gnt;
      bus.acc_rvalid_i = vt[i].rvalid;
      bus.acc_result_i = vt[i].result;
      @(negedge clk);
      chk($sformatf("vec%0d_cpu_gnt", i), 128'(bus.cpu_gnt_o), 128'(vt[i].e_gnt));
      chk($sformatf("vec%0d_acc_req", i), 128'(bus.acc_req_o), 128'(vt[i].e_req));
      chk($sformatf("vec%0d_count", i), 128'(bus.count_o), 128'(vt[i].e_count));
      chk($sformatf("vec%0d_rvalid", i), 128'(bus.cpu_rvalid_o), 128'(vt[i].e_rvalid));
      chk($sformatf("vec%0d_result", i), 128'(bus.cpu_result_o), 128'(vt[i].e_result));
      if (vt[i].e_req) begin
        chk($sformatf("vec%0d_acc_op", i), 128'(bus.acc_op_o), 128'(vt[i].e_op));
        chk($sformatf("vec%0d_acc_opnd", i), 128'(bus.acc_operands_o), 128'({32'd3, 32'd2, 32'd1}));
        chk($sformatf("vec%0d_acc_flags", i), 128'(bus.acc_flags_o), 128'(15'h1234));
      end
      tick();
    end
`else
    // Cut-through on an empty queue
    bus.cpu_req_i = 1'b1;
    bus.cpu_op_i  = 6'h2A;
    bus.acc_gnt_i = 1'b1;
    @(negedge clk);
    chk("byp_acc_req", 128'(bus.acc_req_o), 128'(1));
    chk("byp_cpu_gnt", 128'(bus.cpu_gnt_o), 128'(1));
    chk("byp_acc_op",  128'(bus.acc_op_o), 128'(6'h2A));
    tick();
    bus.cpu_req_i = 1'b0;
    bus.acc_gnt_i = 1'b0;
    bus.acc_rvalid_i = 1'b1;
    bus.acc_result_i = 32'h10;
    @(negedge clk);
    chk("byp_count",   128'(bus.count_o), 128'(0));
    chk("byp_acc_req0", 128'(bus.acc_req_o), 128'(0));
    tick();
    bus.acc_rvalid_i = 1'b0;
    @(negedge clk);
    chk("byp_rvalid",  128'(bus.cpu_rvalid_o), 128'(1));
    tick();
`endif

    // Fill: stall accelerator, 5th request refused while full
    bus.acc_gnt_i    = 1'b0;
    bus.acc_rvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.cpu_req_i = 1'b1;
      bus.cpu_op_i  = 6'(i + 1);
      @(negedge clk);
      chk($sformatf("fill%0d_gnt", i), 128'(bus.cpu_gnt_o), 128'(i < 4));
      chk($sformatf("fill%0d_count", i), 128'(i), 128'(bus.count_o));
      tick();
    end
    // Drain in order; 5th granted once occupancy drops to 3
    begin
      int exp_cnt [5];
      exp_cnt = '{4, 3, 3, 2, 1};
      for (int k = 0; k < 5; k++) begin
        bus.acc_gnt_i    = 1'b1;
        bus.cpu_req_i    = (k <= 1);
        bus.acc_rvalid_i = (k > 0);
        @(negedge clk);
        chk($sformatf("drain%0d_acc_req", k), 128'(bus.acc_req_o), 128'(1));
        chk($sformatf("drain%0d_acc_op", k), 128'(bus.acc_op_o), 128'(k + 1));
        chk($sformatf("drain%0d_count", k), 128'(bus.count_o), 128'(exp_cnt[k]));
        chk($sformatf("drain%0d_cpu_gnt", k), 128'(bus.cpu_gnt_o), 128'(k == 1));
        tick();
      end
    end
    bus.cpu_req_i    = 1'b0;
    bus.acc_gnt_i    = 1'b0;
    bus.acc_rvalid_i = 1'b1;
    @(negedge clk);
    chk("drain_end_acc_req", 128'(bus.acc_req_o), 128'(0));
    chk("drain_end_count",   128'(bus.count_o), 128'(0));
    tick();
    bus.acc_rvalid_i = 1'b0;

    // Outstanding limit
    for (int i = 0; i < 3; i++) begin
      bus.cpu_req_i = 1'b1;
      bus.cpu_op_i  = 6'(8'h11 + i);
      tick();
    end
    bus.cpu_req_i = 1'b0;
    bus.acc_gnt_i = 1'b1;
    @(negedge clk);
    chk("out_a_acc_req", 128'(bus.acc_req_o), 128'(1));
    chk("out_a_count",   128'(bus.count_o), 128'(3));
    tick();
    @(negedge clk);
    chk("out_b_acc_req", 128'(bus.acc_req_o), 128'(1));
    tick();
    bus.acc_rvalid_i = 1'b1;
    bus.acc_result_i = 32'h77;
    @(negedge clk);
    chk("out_c_acc_req", 128'(bus.acc_req_o), 128'(0));
    chk("out_c_count",   128'(bus.count_o), 128'(1));
    tick();
    bus.acc_rvalid_i = 1'b0;
    @(negedge clk);
    chk("out_d_acc_req", 128'(bus.acc_req_o), 128'(1));
    chk("out_d_acc_op",  128'(bus.acc_op_o), 128'(6'h13));
    chk("out_d_rvalid",  128'(bus.cpu_rvalid_o), 128'(1));
    chk("out_d_result",  128'(bus.cpu_result_o), 128'(32'h77));
    tick();
    @(negedge clk);
    chk("out_e_acc_req", 128'(bus.acc_req_o), 128'(0));
    chk("out_e_count",   128'(bus.count_o), 128'(0));
    bus.acc_gnt_i    = 1'b0;
    bus.acc_rvalid_i = 1'b1;
    bus.acc_result_i = 32'h99;
    tick();
    tick();
    bus.acc_rvalid_i = 1'b0;
    @(negedge clk);
    chk("out_drain_result", 128'(bus.cpu_result_o), 128'(32'h99));
    tick();

    // Reset mid-operation: 3 queued, 1 in flight
    for (int i = 0; i < 4; i++) begin
      bus.cpu_req_i = 1'b1;
      bus.cpu_op_i  = 6'(8'h21 + i);
      tick();
    end
    bus.cpu_req_i = 1'b0;
    bus.acc_gnt_i = 1'b1;
    tick();
    bus.acc_gnt_i = 1'b0;
    chk("mid_count", 128'(bus.count_o), 128'(3));
    #2;
    n_reset = 1'b0;
    #1;
    chk("mid_rst_acc_req", 128'(bus.acc_req_o), 128'(0));
    chk("mid_rst_count",   128'(bus.count_o), 128'(0));
    chk("mid_rst_rvalid",  128'(bus.cpu_rvalid_o), 128'(0));
    chk("mid_rst_result",  128'(bus.cpu_result_o), 128'(0));
    tick();
    n_reset = 1'b1;
    bus.acc_rvalid_i = 1'b1;
    bus.acc_result_i = 32'h55;
    tick();
    bus.acc_rvalid_i = 1'b0;
    @(negedge clk);
    chk("late_rsp_rvalid", 128'(bus.cpu_rvalid_o), 128'(0));
    chk("late_rsp_result", 128'(bus.cpu_result_o), 128'(0));
    chk("late_rsp_count",  128'(bus.count_o), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
